// File: rtl/fp_accumulator.sv
// fp_accumulator: sequential stage behind the single-precision float adder.
// It keeps the running sum in a register and presents it on add_x. Each new
// operand goes to add_y, and the adder result is captured on every accepted
// beat. After len terms the final sum and a sticky overflow flag are offered
// on a result handshake.
//
// Float layout on every 32-bit float port: {sign, exp[7:0], mant[22:0]}.
//
// Handshakes: a transfer (beat) happens on a rising clk edge where valid and
// ready are both high. The producer holds data stable while valid is high and
// ready is low. in_ready and res_valid depend only on the state register, so
// neither has a combinational path from any input.
module fp_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic [31:0]      add_x,
    output logic [31:0]      add_y,
    input  logic [31:0]      add_sum,
    input  logic             add_ovf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_ovf,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [31:0]      acc;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
    logic             beat;
    logic             last_beat;

    // An operand is consumed only while the block is accumulating.
    assign beat      = in_valid && in_ready;
    // The counter holds the number of terms still to come, so the beat that
    // sees cnt==1 is the final one. It never decrements past zero.
    assign last_beat = beat && (cnt == CNT_W'(1));

    // The adder sits outside this block. The running sum is operand x and
    // the incoming term is operand y, so add_sum is the candidate next sum.
    assign add_x = acc;
    assign add_y = in_data;

    // Moore outputs, decoded only from registered state.
    assign in_ready  = (state == ACCUM);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign res_data  = acc;
    assign res_ovf   = ovf;
    assign dbg_state = state;

    // Run control: start a run, capture the adder result per beat, and hand
    // off the result. Reset aborts any run in progress immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= 32'h0000_0000;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= 32'h0000_0000;
                        ovf <= 1'b0;
                        cnt <= len;
                        // A zero-length run reports +0.0 without accepting
                        // any operand.
                        if (len == '0) begin
                            state <= DONE;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc <= add_sum;
                        ovf <= ovf | add_ovf;
                        cnt <= cnt - CNT_W'(1);
                        if (last_beat) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // acc and ovf are kept after hand-off. They are cleared
                    // only by the next accepted start.
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_accumulator.sv
// Testbench for fp_accumulator. A behavioural IEEE-754 adder built on real
// arithmetic drives add_sum/add_ovf. Expected results come from integer sums
// of the terms, converted to float.
module tb_fp_accumulator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] add_x;
    logic [31:0] add_y;
    logic [31:0] add_sum;
    logic        add_ovf;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_ovf;
    logic        busy;
    logic [1:0]  dbg_state;
    logic        force_ovf;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    fp_accumulator #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .add_x     (add_x),
        .add_y     (add_y),
        .add_sum   (add_sum),
        .add_ovf   (add_ovf),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ovf   (res_ovf),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- float model ----------------
    // Denormals are flushed to zero. Values used here are small integers, so
    // every sum is exact.
    function automatic real fp_to_real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_fp(input real r);
        logic [63:0] d;
        int e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0) return 32'h0;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic fp_ovf(input real r);
        logic [63:0] d;
        int e;
        if (r == 0.0) return 1'b0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return (e >= 255);
    endfunction

    // Behavioural combinational adder; force_ovf lets a test inject overflow.
    always_comb begin
        add_sum = real_to_fp(fp_to_real(add_x) + fp_to_real(add_y));
        add_ovf = fp_ovf(fp_to_real(add_x) + fp_to_real(add_y)) | force_ovf;
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input int l);
        start = 1'b1;
        len   = 8'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for the result, checks it against the scoreboard, optionally
    // stalls the consumer, then accepts.
    task automatic wait_result(input string name, input logic exp_ovf, input int hold);
        int n;
        logic [31:0] exp_d;
        n = 0;
        while (!res_valid && n < 600) begin
            @(negedge clk);
            n++;
        end
        exp_d = exp_q.pop_front();
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: res_valid=%b after %0d cycles, expected 1", name, res_valid, n);
            return;
        end
        checks++;
        if (res_data !== exp_d) begin
            errors++;
            $display("FAIL %s_res_data: got %h expected %h", name, res_data, exp_d);
        end
        checks++;
        if (res_ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s_res_ovf: got %b expected %b", name, res_ovf, exp_ovf);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp_d || res_ovf !== exp_ovf) begin
                errors++;
                $display("FAIL %s_hold: got valid=%b data=%h ovf=%b expected 1 %h %b",
                         name, res_valid, res_data, res_ovf, exp_d, exp_ovf);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: got valid=%b busy=%b expected 0 0", name, res_valid, busy);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, res_valid, res_ovf, busy} !== 4'b0000 || res_data !== 32'h0 || add_x !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b val=%b ovf=%b busy=%b data=%h x=%h expected all 0",
                     in_ready, res_valid, res_ovf, busy, res_data, add_x);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b rdy=%b expected 0 0", busy, in_ready);
        end
    endtask

    task automatic test_len3();
        logic [31:0] exp_x [3];
        exp_x[0] = 32'h0000_0000;
        exp_x[1] = 32'h3F80_0000;
        exp_x[2] = 32'h4000_0000;
        exp_q.push_back(32'h4040_0000);
        pulse_start(3);
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (add_x !== exp_x[i] || res_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL len3_beat%0d: got x=%h val=%b rdy=%b expected %h 0 1",
                         i, add_x, res_valid, in_ready, exp_x[i]);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        // Fourth cycle after the start edge: the result must already be valid.
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL len3_latency: got res_valid=%b expected 1", res_valid);
        end
        wait_result("len3", 1'b0, 0);
    endtask

    task automatic test_toggle();
        exp_q.push_back(32'h3F80_0000);
        pulse_start(2);
        in_valid = 1'b1;
        in_data  = 32'h4000_0000;
        @(negedge clk);
        in_valid  = 1'b0;
        in_data   = 32'hBF80_0000;
        force_ovf = 1'b1;   // no beat in these cycles, so it must be ignored
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (add_x !== 32'h4000_0000 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL toggle_hold%0d: got x=%h rdy=%b expected 40000000 1", i, add_x, in_ready);
            end
            @(negedge clk);
        end
        force_ovf = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result("toggle", 1'b0, 2);
    endtask

    task automatic test_ovf();
        exp_q.push_back(32'h4000_0000);
        pulse_start(2);
        in_valid  = 1'b1;
        in_data   = 32'h3F80_0000;
        force_ovf = 1'b1;
        @(negedge clk);
        force_ovf = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_continue: got rdy=%b val=%b expected 1 0", in_ready, res_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_result("ovf", 1'b1, 1);
    endtask

    task automatic test_len0();
        exp_q.push_back(32'h0);
        pulse_start(0);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'h0 || res_ovf !== 1'b0) begin
            errors++;
            $display("FAIL len0_result: got val=%b data=%h ovf=%b expected 1 00000000 0",
                     res_valid, res_data, res_ovf);
        end
        // Stall the consumer while poking start and in_valid.
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            len   = 8'd3;
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== 32'h0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL len0_stall%0d: got val=%b data=%h rdy=%b expected 1 00000000 0",
                         i, res_valid, res_data, in_ready);
            end
        end
        in_valid = 1'b0;
        // start coincident with res_ready is not honoured.
        start     = 1'b1;
        len       = 8'd2;
        res_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        res_ready = 1'b0;
        void'(exp_q.pop_front());
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (busy !== 1'b0 || in_ready !== 1'b0 || res_valid !== 1'b0) begin
                errors++;
                $display("FAIL len0_start_in_done%0d: got busy=%b rdy=%b val=%b expected 0 0 0",
                         i, busy, in_ready, res_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        pulse_start(4);
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 || add_x !== 32'h0) begin
            errors++;
            $display("FAIL abort_async: got rdy=%b busy=%b val=%b x=%h expected 0 0 0 00000000",
                     in_ready, busy, res_valid, add_x);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_result: got val=%b busy=%b expected 0 0", res_valid, busy);
        end
        exp_q.push_back(32'h3F80_0000);
        pulse_start(1);
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result("abort_rerun", 1'b0, 0);
    endtask

    task automatic test_random();
        int terms [8];
        int l;
        int total;
        int run;
        int idx;
        int guard;
        logic v;
        for (int r = 0; r < 20; r++) begin
            l = $urandom_range(1, 8);
            total = 0;
            for (int i = 0; i < l; i++) begin
                terms[i] = $urandom_range(0, 120) - 60;
                total += terms[i];
            end
            exp_q.push_back(real_to_fp(real'(total)));
            pulse_start(l);
            run = 0;
            idx = 0;
            guard = 0;
            while (idx < l && guard < 200) begin
                v = ($urandom_range(0, 3) != 0);
                in_valid = v;
                in_data  = real_to_fp(real'(terms[idx]));
                start    = ($urandom_range(0, 5) == 0);
                len      = 8'($urandom_range(0, 255));
                checks++;
                if (add_x !== real_to_fp(real'(run))) begin
                    errors++;
                    $display("FAIL rand%0d_add_x: got %h expected %h", r, add_x, real_to_fp(real'(run)));
                end
                @(negedge clk);
                guard++;
                if (v) begin
                    run += terms[idx];
                    idx++;
                end
            end
            in_valid = 1'b0;
            start    = 1'b0;
            wait_result("rand", 1'b0, $urandom_range(0, 3));
        end
    endtask

    task automatic test_max_len();
        exp_q.push_back(32'h437F_0000);   // 255.0
        pulse_start(255);
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        repeat (254) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || add_x !== 32'h437E_0000) begin
            errors++;
            $display("FAIL max_len_254: got rdy=%b val=%b x=%h expected 1 0 437e0000",
                     in_ready, res_valid, add_x);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL max_len_done: got res_valid=%b expected 1", res_valid);
        end
        wait_result("max_len", 1'b0, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- sequence ----------------
    initial begin
        rst_n     = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        res_ready = 1'b0;
        force_ovf = 1'b0;
        test_reset();
        test_len3();
        test_toggle();
        test_ovf();
        test_len0();
        test_abort();
        test_random();
        test_max_len();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
